serial_sub_4bit: RTL

Bit-serial subtractor for the combinational arithmetic library. It computes `a - b - borrow_in` LSB-first, one bit per clock, through a single full-subtractor cell. It complements the parallel ripple adder by trading latency for area, and uses a start/busy/done handshake so a sequencer can drive it.

---
 rtl/arith_pkg.sv | 12 +
 rtl/full_sub_structural.sv | 16 +
 rtl/serial_sub_4bit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-library types and constants
package arith_pkg;

    localparam int ARITH_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_sub_structural.sv
// rtl/full_sub_structural.sv - combinational 1-bit full subtractor cell
module full_sub_structural (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    logic a_xor_b;

    assign a_xor_b    = a ^ b;
    assign diff       = a_xor_b ^ borrow_in;
    assign borrow_out = (~a & b) | (~a_xor_b & borrow_in);

endmodule

// File: rtl/serial_sub_4bit.sv
// rtl/serial_sub_4bit.sv - bit-serial a-b-borrow_in subtractor; optional SERIAL_SUB_4BIT_OVERFLOW_EN
module serial_sub_4bit
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_4BIT_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             overflow_q, overflow_d;

    logic             cell_diff;
    logic             cell_borrow;

    full_sub_structural u_cell (
        .a          (a_q[cnt_q]),
        .b          (b_q[cnt_q]),
        .borrow_in  (br_q),
        .diff       (cell_diff),
        .borrow_out (cell_borrow)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        br_d         = br_q;
        res_d        = res_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = borrow_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // LSB-first: each new bit enters at the MSB, so after WIDTH shifts bit 0 sits at [0]
                res_d = {cell_diff, res_q[WIDTH-1:1]};
                br_d  = cell_borrow;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d      = DONE;
                    diff_d       = res_d;
                    borrow_out_d = cell_borrow;
                    overflow_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (cell_diff != a_q[WIDTH-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            br_q         <= 1'b0;
            res_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            br_q         <= br_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

`ifdef SERIAL_SUB_4BIT_OVERFLOW_EN
    assign overflow = overflow_q;
`else
    logic unused_overflow;
    assign unused_overflow = overflow_q;
`endif

endmodule
